// File: rtl/gate_chain_pkg.sv
// Shared definitions for the gate-chain delay pipe: reduction mode encodings
// and default geometry.
package gate_chain_pkg;

  localparam int unsigned DEF_WIDTH = 4;
  localparam int unsigned DEF_DEPTH = 8;
  localparam int unsigned DEF_CH    = 3;

  typedef enum logic [1:0] {
    NAND_CASCADE = 2'b00,
    AND_RED      = 2'b01,
    XOR_RED      = 2'b10,
    BYPASS       = 2'b11
  } mode_e;

endpackage

// File: rtl/gate_cascade.sv
// Combinational reduction of the input word to one bit, selected by mode.
module gate_cascade
  import gate_chain_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       mode,
  output logic             r
);

  logic [WIDTH-1:0] chain;

  // chain[k] is the cascade value after folding in d[k]; chain[0] seeds with d0.
  always_comb begin
    chain    = '0;
    chain[0] = in_data[0];
    for (int k = 1; k < WIDTH; k++) begin
      chain[k] = ~(chain[k-1] & in_data[k]);
    end
  end

  always_comb begin
    r = 1'b0;
    unique case (mode_e'(mode))
      NAND_CASCADE: r = chain[WIDTH-1];
      AND_RED:      r = &in_data;
      XOR_RED:      r = ^in_data;
      BYPASS:       r = in_data[0];
      default:      r = 1'b0;
    endcase
  end

endmodule

// File: rtl/gate_chain_pipe.sv
// Reduces each accepted sample to one bit, shifts it into a DEPTH-long delay
// line and exposes CH independently tapped channels with fill-based valids.
module gate_chain_pipe
  import gate_chain_pkg::*;
#(
  parameter  int WIDTH = DEF_WIDTH,
  parameter  int DEPTH = DEF_DEPTH,
  parameter  int CH    = DEF_CH,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WIDTH-1:0]  in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        mode,
  input  logic              freeze,
  input  logic              flush,
  input  logic [CH*AW-1:0]  tap_sel,
  output logic [CH-1:0]     out_data,
  output logic [CH-1:0]     out_valid,
  output logic [AW:0]       fill
);

  logic             r;
  logic             accept;
  logic [DEPTH-1:0] line_q, line_d;
  logic [AW:0]      fill_q, fill_d;

  gate_cascade #(.WIDTH(WIDTH)) u_cascade (
    .in_data (in_data),
    .mode    (mode),
    .r       (r)
  );

  // Flush wins over freeze; either one blocks acceptance.
  assign in_ready = ~freeze & ~flush;
  assign accept   = in_valid & in_ready;

  always_comb begin
    line_d = line_q;
    fill_d = fill_q;
    if (flush) begin
      line_d = '0;
      fill_d = '0;
    end else if (accept) begin
      line_d = {line_q[DEPTH-2:0], r};
      if (fill_q < (AW+1)'(DEPTH)) fill_d = fill_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      line_q <= '0;
      fill_q <= '0;
    end else begin
      line_q <= line_d;
      fill_q <= fill_d;
    end
  end

  assign fill = fill_q;

  // Output zeroing during reset falls out of the async clear of line/fill.
  for (genvar i = 0; i < CH; i++) begin : g_tap
    logic [AW-1:0] sel;
    assign sel          = tap_sel[i*AW +: AW];
    assign out_data[i]  = line_q[sel];
    assign out_valid[i] = (fill_q > {1'b0, sel});
  end

endmodule

// File: tb/tb_gate_chain_pipe.sv
// Scoreboard bench for gate_chain_pipe: a queue-of-history reference model
// predicts every post-edge output set, a monitor compares after each edge.
module tb_gate_chain_pipe;
  import gate_chain_pkg::*;

  localparam int WIDTH = 4;
  localparam int DEPTH = 8;
  localparam int CH    = 3;
  localparam int AW    = 3;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [WIDTH-1:0]  in_data = '0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [1:0]        mode = '0;
  logic              freeze = 1'b0;
  logic              flush = 1'b0;
  logic [CH*AW-1:0]  tap_sel = '0;
  logic [CH-1:0]     out_data;
  logic [CH-1:0]     out_valid;
  logic [AW:0]       fill;

  gate_chain_pipe #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CH(CH)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .mode(mode), .freeze(freeze), .flush(flush),
    .tap_sel(tap_sel), .out_data(out_data), .out_valid(out_valid), .fill(fill)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [CH-1:0] od;
    logic [CH-1:0] ov;
    logic [AW:0]   fill;
    logic          rdy;
  } exp_t;

  exp_t sbq[$];
  logic hist[$];   // accepted results, newest first, at most DEPTH kept
  int   checks   = 0;
  int   failures = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic ref_r(input logic [WIDTH-1:0] d, input logic [1:0] m);
    logic c;
    c = d[0];
    case (m)
      2'd0: begin
        for (int k = 1; k < WIDTH; k++) c = ~(c & d[k]);
        return c;
      end
      2'd1:    return &d;
      2'd2:    return ^d;
      default: return d[0];
    endcase
  endfunction

  function automatic exp_t model_out();
    exp_t e;
    int   t;
    e.rdy  = ~(freeze | flush);
    e.fill = (AW+1)'(hist.size());
    for (int i = 0; i < CH; i++) begin
      t = int'(tap_sel[i*AW +: AW]);
      e.od[i] = (t < hist.size()) ? hist[t] : 1'b0;
      e.ov[i] = (hist.size() > t);
    end
    return e;
  endfunction

  task automatic step(input logic v, input logic [1:0] m, input logic [WIDTH-1:0] d,
                      input logic fz, input logic fl, input logic [CH*AW-1:0] ts);
    @(negedge clk);
    in_valid = v; mode = m; in_data = d; freeze = fz; flush = fl; tap_sel = ts;
    @(posedge clk);
    if (fl) hist.delete();
    else if (v && !fz) begin
      hist.push_front(ref_r(d, m));
      if (hist.size() > DEPTH) void'(hist.pop_back());
    end
    sbq.push_back(model_out());
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        chk("sb_out_data",  int'(out_data),  int'(e.od));
        chk("sb_out_valid", int'(out_valid), int'(e.ov));
        chk("sb_fill",      int'(fill),      int'(e.fill));
        chk("sb_in_ready",  int'(in_ready),  int'(e.rdy));
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin : driver
    logic [CH*AW-1:0] ts;
    logic [7:0]       seq;
    int               f0;
    seq = 8'b1011_0010;

    #12;
    chk("rst_out_data",  int'(out_data), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_fill",      int'(fill), 0);
    @(negedge clk);
    rst = 1'b0;

    // NAND cascade truth
    ts = '0;
    step(1, 2'd0, 4'b1111, 0, 0, ts); #2 chk("nand_1111", int'(out_data[0]), 0);
    step(1, 2'd0, 4'b0000, 0, 0, ts); #2 chk("nand_0000", int'(out_data[0]), 1);
    step(1, 2'd0, 4'b0111, 0, 0, ts); #2 chk("nand_0111", int'(out_data[0]), 1);

    // delay/latency with taps 0,3,7
    step(0, 2'd0, 4'b0, 0, 1, ts);
    ts = {3'd7, 3'd3, 3'd0};
    for (int i = 7; i >= 0; i--) step(1, 2'd3, {3'b0, seq[i]}, 0, 0, ts);
    #2;
    chk("lat_out_data",  int'(out_data), 3'b100);
    chk("lat_out_valid", int'(out_valid), 3'b111);
    chk("lat_fill",      int'(fill), 8);
    step(1, 2'd3, 4'b0001, 0, 0, ts); #2 chk("sat_fill", int'(fill), 8);

    // partial fill
    step(0, 2'd0, 4'b0, 0, 1, ts);
    for (int i = 0; i < 3; i++) step(1, 2'd2, 4'(i + 3), 0, 0, ts);
    #2 chk("part_ov1_lo", int'(out_valid[1]), 0);
    step(1, 2'd2, 4'b1000, 0, 0, ts);
    #2 chk("part_ov1_hi", int'(out_valid[1]), 1);

    // freeze with valid offered
    f0 = int'(fill);
    for (int i = 0; i < 5; i++) begin
      step(1, 2'd3, 4'b0001, 1, 0, ts);
      #2 chk("frz_in_ready", int'(in_ready), 0);
    end
    chk("frz_fill_held", int'(fill), f0);
    step(1, 2'd3, 4'b0001, 0, 0, ts);
    #2 chk("frz_release_fill", int'(fill), f0 + 1);

    // flush + freeze + valid at fill 5
    step(1, 2'd3, 4'b0001, 1, 1, ts);
    #2;
    chk("flush_fill",      int'(fill), 0);
    chk("flush_out_valid", int'(out_valid), 0);
    chk("flush_out_data",  int'(out_data), 0);

    // async reset mid-stream at fill 6
    for (int i = 0; i < 6; i++) step(1, 2'd3, 4'b0001, 0, 0, ts);
    step(0, 2'd0, 4'b0, 0, 0, ts);
    #3 rst = 1'b1;
    #1;
    chk("arst_out_data",  int'(out_data), 0);
    chk("arst_out_valid", int'(out_valid), 0);
    chk("arst_fill",      int'(fill), 0);
    chk("arst_in_ready",  int'(in_ready), 1);
    hist.delete();
    @(negedge clk);
    rst = 1'b0;
    step(1, 2'd3, 4'b0001, 0, 0, ts);
    #2;
    chk("arst_tap0", int'(out_data[0]), 1);
    chk("arst_fill1", int'(fill), 1);

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      step($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), 4'($urandom),
           $urandom_range(0, 99) < 15, $urandom_range(0, 99) < 5,
           {3'($urandom), 3'($urandom), 3'($urandom)});
    end

    step(0, 2'd0, 4'b0, 0, 0, ts);
    for (int n = 0; n < 10 && sbq.size() != 0; n++) @(posedge clk);
    #2;
    chk("sb_drained", sbq.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
